// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- 8N1 UART transmitter.
//
// Sends one start bit (0), eight data bits LSB first, and one stop bit (1).
// Each bit is held for CLKS_PER_BIT sysclk cycles. A start request is accepted
// in any IDLE cycle, including the cycle that carries the done pulse, so
// holding i_tx_start high sends frames every 10*CLKS_PER_BIT+1 cycles.
//
// Ports:
//   sysclk      in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   i_tx_start  in   start request, sampled on the rising edge
//   i_tx_data   in   byte to send, captured when a start is accepted
//   o_tx_serial out  TX line, idles high (registered)
//   o_tx_active out  high while a frame is on the line (registered)
//   o_tx_done   out  one-cycle pulse at the end of a frame (registered)
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ     = 125_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             serial_q,  serial_d;
    logic             active_q,  active_d;
    logic             done_q,    done_d;

    logic             bit_end;

    // Last cycle of the current bit period.
    assign bit_end = (cnt_q == CNT_LAST);

    // State register and output flops.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so every port is driven straight from a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                serial_d = 1'b1;
                active_d = 1'b0;
                if (i_tx_start) begin
                    state_d   = S_START;
                    shift_d   = i_tx_data;
                    bit_idx_d = '0;
                    serial_d  = 1'b0;
                    active_d  = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    serial_d  = shift_q[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d  = S_STOP;
                        serial_d = 1'b1;
                    end else begin
                        // Shift right so the next bit to send is always in
                        // position 1 now and position 0 after this edge.
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        serial_d  = shift_q[1];
                    end
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    serial_d = 1'b1;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                serial_d = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    assign o_tx_serial = serial_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- bench for uart_tx.
//
// Two instances share clock and reset: dut_a at 10 cycles per bit and dut_b at
// default parameters (1085 cycles per bit). A frame-level model predicts the
// three outputs of both instances from the accepted start edge and byte, and
// is compared every cycle. Directed tests add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB_A = 10;
    localparam int CPB_B = 1085;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] data_a,  data_b;
    logic       ser_a, act_a, done_a;
    logic       ser_b, act_b, done_b;

    always #5 sysclk = ~sysclk;

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut_a (
        .sysclk      (sysclk),
        .rst         (rst),
        .i_tx_start  (start_a),
        .i_tx_data   (data_a),
        .o_tx_serial (ser_a),
        .o_tx_active (act_a),
        .o_tx_done   (done_a)
    );

    uart_tx dut_b (
        .sysclk      (sysclk),
        .rst         (rst),
        .i_tx_start  (start_b),
        .i_tx_data   (data_b),
        .o_tx_serial (ser_b),
        .o_tx_active (act_b),
        .o_tx_done   (done_b)
    );

    // ---------------- frame-level model ----------------
    int         cyc = 0;          // rising edges seen so far
    bit         have  [2];        // a frame has been accepted since reset
    int         e0    [2];        // edge number of the accepting edge
    logic [7:0] mbyte [2];

    function automatic int cpb_of(input int i);
        return (i == 0) ? CPB_A : CPB_B;
    endfunction

    // Idle means the previous cycle was not inside a frame.
    function automatic logic model_idle(input int i);
        return !have[i] || ((cyc - e0[i]) >= 10 * cpb_of(i));
    endfunction

    // Returns {serial, active, done} expected in the current cycle.
    function automatic logic [2:0] model_out(input int i);
        int   t, b, cpb;
        logic s, a, d;
        cpb = cpb_of(i);
        s = 1'b1; a = 1'b0; d = 1'b0;
        if (have[i]) begin
            t = cyc - e0[i];
            if (t < 10 * cpb) begin
                a = 1'b1;
                b = t / cpb;
                if (b == 0)     s = 1'b0;
                else if (b < 9) s = mbyte[i][b-1];
            end else if (t == 10 * cpb) begin
                d = 1'b1;
            end
        end
        return {s, a, d};
    endfunction

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(posedge sysclk or posedge rst) begin
        if (rst) begin
            have[0] <= 1'b0;
            have[1] <= 1'b0;
        end else begin
            if (model_idle(0) && start_a) begin
                have[0] <= 1'b1; e0[0] <= cyc + 1; mbyte[0] <= data_a;
            end
            if (model_idle(1) && start_b) begin
                have[1] <= 1'b1; e0[1] <= cyc + 1; mbyte[1] <= data_b;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int cmp_checks = 0;
    int cmp_errors = 0;

    always @(negedge sysclk) begin
        cmp_checks <= cmp_checks + 2;
        cmp_errors <= cmp_errors
                    + ((({ser_a, act_a, done_a}) !== model_out(0)) ? 1 : 0)
                    + ((({ser_b, act_b, done_b}) !== model_out(1)) ? 1 : 0);
        if ({ser_a, act_a, done_a} !== model_out(0) && cmp_errors < 20)
            $display("FAIL model_a cyc=%0d got s/a/d=%b need %b",
                     cyc, {ser_a, act_a, done_a}, model_out(0));
        if ({ser_b, act_b, done_b} !== model_out(1) && cmp_errors < 20)
            $display("FAIL model_b cyc=%0d got s/a/d=%b need %b",
                     cyc, {ser_b, act_b, done_b}, model_out(1));
    end

    // ---------------- directed tests ----------------
    int   checks = 0;
    int   errors = 0;
    logic rs [0:255];
    logic ra [0:255];
    logic rd [0:255];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0d need=%0d", name, act, req);
        end
    endtask

    // Byte reassembled from mid-bit samples of a recorded dut_a frame.
    function automatic logic [7:0] decode_a(input int base);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = rs[base + 5 + 10 * (k + 1)];
        return v;
    endfunction

    function automatic int count_hi(input int which, input int lo, input int hi);
        int n = 0;
        for (int t = lo; t <= hi; t++) begin
            if (which == 0 && rs[t] === 1'b1) n++;
            if (which == 1 && ra[t] === 1'b1) n++;
            if (which == 2 && rd[t] === 1'b1) n++;
        end
        return n;
    endfunction

    task automatic rec(input int t);
        rs[t] = ser_a; ra[t] = act_a; rd[t] = done_a;
    endtask

    initial begin
        logic [9:0] exp_a5;
        logic [9:0] rx;
        int         act_cnt, done_cnt, done_at, first_rise, first_low;

        exp_a5 = 10'b11_0100_1010;  // frame bits 0..9 for 8'hA5, bit 0 first
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;

        // Reset state
        repeat (3) @(negedge sysclk);
        check("rst_serial", ser_a, 1);
        check("rst_active", act_a, 0);
        check("rst_done",   done_a, 0);
        rst = 1'b0;
        repeat (5) @(negedge sysclk);
        check("post_rst_serial", ser_a, 1);
        check("post_rst_active", act_a, 0);

        // Single frame, 8'hA5
        @(negedge sysclk); data_a = 8'hA5; start_a = 1'b1;
        for (int t = 0; t < 120; t++) begin
            @(negedge sysclk);
            if (t == 0) start_a = 1'b0;
            rec(t);
        end
        for (int k = 0; k < 10; k++) check($sformatf("a5_bit%0d", k), rs[5 + 10 * k], exp_a5[k]);
        check("a5_active_width", count_hi(1, 0, 119), 100);
        check("a5_active_end",   ra[100], 0);
        check("a5_done_count",   count_hi(2, 0, 119), 1);
        check("a5_done_at100",   rd[100], 1);

        // Busy rejection: new start and data mid-frame at data bit 4
        @(negedge sysclk); data_a = 8'hA5; start_a = 1'b1;
        for (int t = 0; t < 130; t++) begin
            @(negedge sysclk);
            if (t == 0)  start_a = 1'b0;
            if (t == 52) begin start_a = 1'b1; data_a = 8'h3C; end
            if (t == 53) start_a = 1'b0;
            rec(t);
        end
        for (int k = 0; k < 10; k++) check($sformatf("busy_bit%0d", k), rs[5 + 10 * k], exp_a5[k]);
        check("busy_active_width", count_hi(1, 0, 129), 100);
        check("busy_done_count",   count_hi(2, 0, 129), 1);
        check("busy_done_at100",   rd[100], 1);

        // Back-to-back with start held high
        @(negedge sysclk); data_a = 8'h00; start_a = 1'b1;
        for (int t = 0; t < 215; t++) begin
            @(negedge sysclk);
            if (t == 0)   data_a = 8'hFF;
            if (t == 101) start_a = 1'b0;
            rec(t);
        end
        first_low = -1;
        for (int t = 90; t < 215; t++) if (first_low < 0 && rs[t] === 1'b0) first_low = t;
        check("b2b_second_start", first_low, 101);
        check("b2b_gap_high",     count_hi(0, 90, 100), 11);
        check("b2b_last_data0",   rs[89], 0);
        check("b2b_first_byte",   decode_a(0), 8'h00);
        check("b2b_second_byte",  decode_a(101), 8'hFF);
        check("b2b_done1",        rd[100], 1);
        check("b2b_done2",        rd[201], 1);
        check("b2b_active2",      count_hi(1, 101, 214), 100);

        // Reset during data bit 3, then a fresh frame
        @(negedge sysclk); data_a = 8'hC3; start_a = 1'b1;
        for (int t = 0; t < 150; t++) begin
            @(negedge sysclk);
            if (t == 0) start_a = 1'b0;
            if (t == 44) begin
                #2 rst = 1'b1;
                #1;
                check("arst_serial", ser_a, 1);
                check("arst_active", act_a, 0);
                check("arst_done",   done_a, 0);
            end
            if (t == 46) rst = 1'b0;
            rec(t);
        end
        check("arst_was_active", ra[43], 1);
        check("arst_no_done",    count_hi(2, 0, 149), 0);
        check("arst_line_idle",  count_hi(0, 45, 149), 105);
        @(negedge sysclk); data_a = 8'h5A; start_a = 1'b1;
        for (int t = 0; t < 120; t++) begin
            @(negedge sysclk);
            if (t == 0) start_a = 1'b0;
            rec(t);
        end
        check("after_rst_startbit", rs[5], 0);
        check("after_rst_byte",     decode_a(0), 8'h5A);
        check("after_rst_stopbit",  rs[95], 1);
        check("after_rst_done",     rd[100], 1);

        // Default parameters, 8'h0F
        @(negedge sysclk); data_b = 8'h0F; start_b = 1'b1;
        act_cnt = 0; done_cnt = 0; done_at = -1; first_rise = -1; rx = '0;
        for (int t = 0; t < 10900; t++) begin
            @(negedge sysclk);
            if (t == 0) start_b = 1'b0;
            if (act_b === 1'b1) act_cnt++;
            if (done_b === 1'b1) begin done_cnt++; done_at = t; end
            if (first_rise < 0 && t > 0 && ser_b === 1'b1) first_rise = t;
            if (t % CPB_B == CPB_B / 2 && t / CPB_B < 10) rx[t / CPB_B] = ser_b;
        end
        check("def_bit_period",   first_rise, 1085);
        check("def_active_width", act_cnt, 10850);
        check("def_startbit",     rx[0], 0);
        check("def_byte",         rx[8:1], 8'h0F);
        check("def_stopbit",      rx[9], 1);
        check("def_done_count",   done_cnt, 1);
        check("def_done_at",      done_at, 10850);

        repeat (3) @(negedge sysclk);
        #1;
        errors = errors + cmp_errors;
        checks = checks + cmp_checks;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
